// File: rtl/ddr4_cmd_sequencer_if.sv
// Request, command and completion signals between the request queue, the
// DDR4 command sequencer and the command consumer.
interface ddr4_cmd_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [13:0] cmd_row;
  logic [10:0] cmd_col;
  logic        done_valid;
  logic [1:0]  done_op;

  modport master (
    output req_valid, req_op, req_addr,
    input  req_ready, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col,
           done_valid, done_op
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    output req_ready, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col,
           done_valid, done_op
  );
endinterface

// File: rtl/ddr4_cmd_sequencer.sv
// DDR4 command sequencer: one request at a time, open-page policy, per-bank
// row tracking and timing windows.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | req_ready=1, waiting for a request
// EVAL   | request latched; hit/miss/closed decided combinationally and
//        | the first command may issue in this same cycle
// PRE    | waiting for pre_cnt of the target bank, then PRE
// ACT    | waiting for act_cnt of the target bank, then ACT
// COL    | waiting for col_cnt and ccd_cnt, then RD/WR
// WAIT   | counting down the data phase, then done pulse
//
// Counters hold "cycles remaining minus one": a command registered at edge t
// that must be followed N cycles later loads N-1, so the counter reads 0 in
// the cycle before edge t+N, when the dependent command is decided.
module ddr4_cmd_sequencer #(
  parameter int TRCD   = 24,
  parameter int TRP    = 24,
  parameter int TRAS   = 52,
  parameter int TCL    = 24,
  parameter int TCWL   = 20,
  parameter int TBURST = 4,
  parameter int TWR    = 20,
  parameter int TCCD_L = 8,
  parameter int CW     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ddr4_cmd_sequencer_if.slave   bus
);

  localparam logic [CW-1:0] RCD_M1     = CW'(TRCD - 1);
  localparam logic [CW-1:0] RP_M1      = CW'(TRP - 1);
  localparam logic [CW-1:0] RAS_M1     = CW'(TRAS - 1);
  localparam logic [CW-1:0] CCD_M1     = CW'(TCCD_L - 1);
  localparam logic [CW-1:0] RD_PRE_M1  = CW'(TBURST - 1);
  localparam logic [CW-1:0] WR_PRE_M1  = CW'(TCWL + TBURST + TWR - 1);
  localparam logic [CW-1:0] RD_WAIT_M1 = CW'(TCL + TBURST - 1);
  localparam logic [CW-1:0] WR_WAIT_M1 = CW'(TCWL + TBURST - 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_PRE, S_ACT, S_COL, S_WAIT} state_t;

  state_t        state_q, state_d, phase;
  logic [1:0]    op_q;
  logic [13:0]   row_q;
  logic [10:0]   col_q;
  logic [3:0]    bidx_q;
  logic [15:0]   open_q;
  logic [13:0]   open_row_q [16];
  logic [CW-1:0] pre_cnt_q [16];
  logic [CW-1:0] act_cnt_q [16];
  logic [CW-1:0] col_cnt_q [16];
  logic [CW-1:0] ccd_cnt_q, wait_cnt_q;
  logic          accept, issue_pre, issue_act, issue_col, finish, is_wr;

  logic          cmd_valid_q, done_valid_q;
  logic [2:0]    cmd_q;
  logic [1:0]    cmd_bg_q, cmd_bank_q, done_op_q;
  logic [13:0]   cmd_row_q;
  logic [10:0]   cmd_col_q;

  logic          unused_addr;
  assign unused_addr = ^bus.req_addr[2:0];

  function automatic logic [CW-1:0] dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  function automatic logic [CW-1:0] cnt_max(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign is_wr = (op_q == 2'd1);

  // Next state and issue decisions; EVAL folds into PRE/ACT/COL in place.
  always_comb begin
    accept    = bus.req_valid && (state_q == S_IDLE);
    phase     = state_q;
    state_d   = state_q;
    issue_pre = 1'b0;
    issue_act = 1'b0;
    issue_col = 1'b0;
    finish    = 1'b0;
    if (state_q == S_EVAL) begin
      if (open_q[bidx_q]) phase = (open_row_q[bidx_q] == row_q) ? S_COL : S_PRE;
      else                phase = S_ACT;
    end
    case (phase)
      S_IDLE: if (accept) state_d = S_EVAL;
      S_PRE: begin
        state_d = S_PRE;
        if (pre_cnt_q[bidx_q] == '0) begin
          issue_pre = 1'b1;
          state_d   = S_ACT;
        end
      end
      S_ACT: begin
        state_d = S_ACT;
        if (act_cnt_q[bidx_q] == '0) begin
          issue_act = 1'b1;
          state_d   = S_COL;
        end
      end
      S_COL: begin
        state_d = S_COL;
        if (col_cnt_q[bidx_q] == '0 && ccd_cnt_q == '0) begin
          issue_col = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Latch the accepted request in decoded form.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      row_q  <= '0;
      col_q  <= '0;
      bidx_q <= '0;
    end else if (accept) begin
      op_q   <= bus.req_op;
      row_q  <= bus.req_addr[31:18];
      col_q  <= {bus.req_addr[17:10], bus.req_addr[5:3]};
      bidx_q <= {bus.req_addr[7:6], bus.req_addr[9:8]};
    end
  end

  // Per-bank open rows and timing windows; all banks count down every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      for (int i = 0; i < 16; i++) begin
        open_row_q[i] <= '0;
        pre_cnt_q[i]  <= '0;
        act_cnt_q[i]  <= '0;
        col_cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        pre_cnt_q[i] <= dec(pre_cnt_q[i]);
        act_cnt_q[i] <= dec(act_cnt_q[i]);
        col_cnt_q[i] <= dec(col_cnt_q[i]);
      end
      if (issue_pre) begin
        open_q[bidx_q]    <= 1'b0;
        act_cnt_q[bidx_q] <= RP_M1;
      end
      if (issue_act) begin
        open_q[bidx_q]     <= 1'b1;
        open_row_q[bidx_q] <= row_q;
        col_cnt_q[bidx_q]  <= RCD_M1;
        pre_cnt_q[bidx_q]  <= RAS_M1;
      end
      if (issue_col)
        pre_cnt_q[bidx_q] <= cnt_max(dec(pre_cnt_q[bidx_q]), is_wr ? WR_PRE_M1 : RD_PRE_M1);
    end
  end

  // Column-to-column spacing and data-phase countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccd_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      ccd_cnt_q  <= issue_col ? CCD_M1 : dec(ccd_cnt_q);
      wait_cnt_q <= issue_col ? (is_wr ? WR_WAIT_M1 : RD_WAIT_M1) : dec(wait_cnt_q);
    end
  end

  // Registered command and completion outputs; fields are zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q  <= 1'b0;
      cmd_q        <= CMD_NOP;
      cmd_bg_q     <= '0;
      cmd_bank_q   <= '0;
      cmd_row_q    <= '0;
      cmd_col_q    <= '0;
      done_valid_q <= 1'b0;
      done_op_q    <= '0;
    end else begin
      cmd_valid_q  <= issue_pre | issue_act | issue_col;
      cmd_q        <= issue_pre ? CMD_PRE :
                      issue_act ? CMD_ACT :
                      issue_col ? (is_wr ? CMD_WR : CMD_RD) : CMD_NOP;
      cmd_bg_q     <= (issue_pre | issue_act | issue_col) ? bidx_q[3:2] : 2'd0;
      cmd_bank_q   <= (issue_pre | issue_act | issue_col) ? bidx_q[1:0] : 2'd0;
      cmd_row_q    <= issue_act ? row_q : 14'd0;
      cmd_col_q    <= issue_col ? col_q : 11'd0;
      done_valid_q <= finish;
      done_op_q    <= finish ? op_q : 2'd0;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_bg     = cmd_bg_q;
  assign bus.cmd_bank   = cmd_bank_q;
  assign bus.cmd_row    = cmd_row_q;
  assign bus.cmd_col    = cmd_col_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_op    = done_op_q;

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Bench for ddr4_cmd_sequencer: request table with expected command timing,
// scoreboard queue of expected command/done events, plus a reset corner case.
module tb_ddr4_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr4_cmd_sequencer_if bus();

  ddr4_cmd_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         t;
    int         kind;   // 1..4 command code, 5 = done
    logic [1:0] bg;
    logic [1:0] bank;
    logic [13:0] row;
    logic [10:0] col;
    logic [1:0] op;
  } ev_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    int          pre_off;
    int          act_off;
    int          col_off;
    int          done_off;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[11];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int t, input int kind, input logic [31:0] addr, input logic [1:0] op);
    ev_t e;
    e.t    = t;
    e.kind = kind;
    e.bg   = addr[7:6];
    e.bank = addr[9:8];
    e.row  = (kind == 1) ? addr[31:18] : 14'd0;
    e.col  = (kind == 2 || kind == 3) ? {addr[17:10], addr[5:3]} : 11'd0;
    e.op   = (kind == 5) ? op : 2'd0;
    exp_q.push_back(e);
  endtask

  // Scoreboard: compare each DUT event against the oldest expectation.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n) begin
        if (bus.cmd_valid) begin
          if (exp_q.size() == 0 || exp_q[0].kind == 5) begin
            check("cmd_unexpected", {63'd0, bus.cmd_valid}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("cmd_event",
                  {32'(cyc), bus.cmd, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col},
                  {32'(e.t), 3'(e.kind), e.bg, e.bank, e.row, e.col});
          end
        end else begin
          check("idle_fields",
                {32'd0, bus.cmd, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col}, 64'd0);
        end
        if (bus.done_valid) begin
          done_seen++;
          if (exp_q.size() == 0 || exp_q[0].kind != 5) begin
            check("done_unexpected", {63'd0, bus.done_valid}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("done_event", {30'd0, 32'(cyc), bus.done_op}, {30'd0, 32'(e.t), e.op});
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] addr, output int a);
    int n = 0;
    while (!bus.req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("ready_timeout", {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    a = cyc + 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_addr  = 32'd0;
  endtask

  task automatic push_vec(input vec_t v, input int a);
    if (v.pre_off  >= 0) push_ev(a + v.pre_off, 4, v.addr, v.op);
    if (v.act_off  >= 0) push_ev(a + v.act_off, 1, v.addr, v.op);
    if (v.col_off  >= 0) push_ev(a + v.col_off, (v.op == 2'd1) ? 3 : 2, v.addr, v.op);
    if (v.done_off >= 0) push_ev(a + v.done_off, 5, v.addr, v.op);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int   a;
    int   d0;
    vec_t v;

    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_addr  = 32'd0;

    //         op     addr          pre act col done
    vecs[0]  = '{2'd0, 32'h0004_0000, -1,  1, 25, 53};  // closed bank, row 1
    vecs[1]  = '{2'd0, 32'h0004_0400, -1, -1,  1, 29};  // page hit, col_hi=1
    vecs[2]  = '{2'd0, 32'h0008_0000,  1, 25, 49, 77};  // page miss, row 2
    vecs[3]  = '{2'd1, 32'h0008_0028, -1, -1,  1, 25};  // write hit, col_lo=5
    vecs[4]  = '{2'd0, 32'h000C_0000, 19, 43, 67, 95};  // miss held by write recovery
    vecs[5]  = '{2'd2, 32'h0014_0380, -1,  1, 25, 53};  // ifetch, bg2 bank3 closed
    vecs[6]  = '{2'd3, 32'h0017_FFB8, -1, -1,  1, 29};  // reserved op, max column
    vecs[7]  = '{2'd1, 32'h001C_0240, -1,  1, 25, 49};  // write to closed bg1 bank2
    vecs[8]  = '{2'd0, 32'h001C_0240, -1, -1,  1, 29};  // read hit after write
    vecs[9]  = '{2'd0, 32'h0020_0240,  1, 25, 49, 77};  // miss after recovery elapsed
    vecs[10] = '{2'd0, 32'h000C_0000, -1, -1,  1, 29};  // bank0 row 3 still open

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {27'd0, bus.req_ready, bus.cmd_valid, bus.cmd, bus.cmd_bg, bus.cmd_bank,
           bus.cmd_row, bus.cmd_col, bus.done_valid, bus.done_op},
          {27'd0, 1'b1, 36'd0});
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      send(v.op, v.addr, a);
      check("ready_busy", {63'd0, bus.req_ready}, 64'd0);
      push_vec(v, a);
      wait_drain("drain_vec");
    end

    // Reset while waiting for tRCD: outputs clear at once, no done pulse.
    send(2'd0, 32'h0024_03C0, a);
    push_ev(a + 1, 1, 32'h0024_03C0, 2'd0);
    @(negedge clk);
    check("act_before_reset", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    check("reset_async",
          {27'd0, bus.req_ready, bus.cmd_valid, bus.cmd, bus.cmd_bg, bus.cmd_bank,
           bus.cmd_row, bus.cmd_col, bus.done_valid, bus.done_op},
          {27'd0, 1'b1, 36'd0});
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_seen;
    repeat (80) @(negedge clk);
    check("no_done_after_reset", 64'(done_seen - d0), 64'd0);

    // Banks are closed again: same address and a formerly open bank both ACT.
    v = '{2'd0, 32'h0024_03C0, -1, 1, 25, 53};
    send(v.op, v.addr, a);
    push_vec(v, a);
    wait_drain("drain_reset_same");
    v = '{2'd0, 32'h0004_0000, -1, 1, 25, 53};
    send(v.op, v.addr, a);
    push_vec(v, a);
    wait_drain("drain_reset_bank0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr4_cmd_sequencer.md
Name: ddr4_cmd_sequencer

Overview:
- Downstream stage of the trace-driven request queue in the DDR4 controller simulator.
- Accepts one decoded request at a time (op + 32-bit address) and sequences DDR4 commands under an open-page policy: PRE, ACT, RD or WR.
- Tracks the open row of all 16 banks (4 bank groups x 4 banks) and enforces the core DRAM timing windows.
- Signals completion so the queue can pop the head entry.

Parameters:
- tRCD, 24, cycles from ACT to the first RD/WR on that bank
- tRP, 24, cycles from PRE to ACT on that bank
- tRAS, 52, minimum cycles from ACT to PRE on that bank
- tCL, 24, RD to first data beat
- tCWL, 20, WR to first data beat
- tBURST, 4, data burst length in cycles
- tWR, 20, write recovery after the last write data beat, before PRE
- tCCD_L, 8, minimum spacing between any two column commands (RD/WR)
- CW, 8, width of every timing counter; all parameters must be < 2^CW

Ports:
- clk, in, 1, controller clock
- rst_n, in, 1, asynchronous active-low reset
- req_valid, in, 1, request present
- req_ready, out, 1, sequencer can accept a request
- req_op, in, 2, 0=data read, 1=data write, 2=instruction fetch (read), 3=reserved (treated as read)
- req_addr, in, 32, row=[31:18], col_hi=[17:10], bank=[9:8], bg=[7:6], col_lo=[5:3]
- cmd_valid, out, 1, a command is issued this cycle
- cmd, out, 3, 0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE
- cmd_bg, out, 2, bank group of the command
- cmd_bank, out, 2, bank of the command
- cmd_row, out, 14, row (meaningful on ACT)
- cmd_col, out, 11, {col_hi,col_lo} (meaningful on RD/WR)
- done_valid, out, 1, one-cycle completion pulse
- done_op, out, 2, op of the completed request

Behaviour:
- Reset (async assert, sync release):
  - All banks closed; every counter = 0; state = IDLE.
  - req_ready=1, cmd_valid=0, cmd=0, cmd_bg/bank/row/col=0, done_valid=0, done_op=0.
  - Reset mid-operation discards the latched request; no done pulse is produced for it.
- Handshake: transfer when req_valid && req_ready. req_ready=1 only in IDLE. The request is latched at cycle A; the first command may issue at cycle A+1.
- Counter rule: a command at cycle t that loads a counter with N permits the dependent command at cycle t+N. Counters decrement to 0 and saturate there.
- Per-bank state: open flag, 14-bit open row, pre_cnt (earliest PRE), act_cnt (earliest ACT), col_cnt (earliest RD/WR). One global ccd_cnt.
- FSM:
  - IDLE: wait for a request.
  - EVAL: if the bank is open and its row matches -> COL. If open and the row differs -> PRE. If closed -> ACT.
  - PRE: issue when pre_cnt==0. Clear the open flag; act_cnt=tRP; -> ACT.
  - ACT: issue when act_cnt==0. Set open flag and row; col_cnt=tRCD; pre_cnt=tRAS; -> COL.
  - COL: issue RD/WR when col_cnt==0 && ccd_cnt==0. Set ccd_cnt=tCCD_L.
    - RD: pre_cnt=max(pre_cnt,tBURST); data wait = tCL+tBURST.
    - WR: pre_cnt=max(pre_cnt,tCWL+tBURST+tWR); data wait = tCWL+tBURST.
    - -> WAIT_DATA.
  - WAIT_DATA: count down the data wait. At 0, pulse done_valid with the latched op -> IDLE. req_ready becomes 1 the next cycle.
  - EVAL takes zero cycles: it is combinational in the cycle after accept, so the first command can issue at A+1.
- Issue rules:
  - At most one command per cycle.
  - cmd_valid=0 and cmd=NOP while waiting on a counter.
  - Command fields are registered and are 0 when cmd_valid=0.
- Counters of other banks keep decrementing in every state.
- Rows stay open after completion (open-page policy). There is no refresh and no auto-precharge.

Test Plan:
- Closed-bank read: after reset, read addr 0x0004_0000 accepted at cycle 0 -> ACT row1 @1, RD @25, done_valid @53 with done_op=0.
- Page hit: follow-up read, same row, col_hi=1, accepted @54 -> no ACT/PRE; RD @55; done @83.
- Page miss: same bank, row 2, accepted @54 -> PRE @55, ACT @79, RD @103, done @131.
- Write recovery: write on bank0 with WR @t, then a miss on bank0 -> PRE not before t+44 (20+4+20); done for the write @t+24.
- tRAS hold: ACT @1, then a miss on the same bank accepted before cycle 53 -> PRE no earlier than @53.
- Async reset asserted during WAIT_RCD -> outputs zero immediately; no done pulse. The next request to the same address issues ACT (bank closed).
